// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: instruction word width, PC/address width and
// the program-loader state encoding.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int PC_W   = 4;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LOAD,
        LD_FILL,
        LD_HOLD,
        LD_RUN
    } ld_state_t;

endpackage

// File: rtl/prog_loader_addr_ctr.sv
// Instruction-memory write address counter with synchronous clear, increment
// and a flag marking the final word of the memory.
module prog_loader_addr_ctr #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = cpu_pkg::PC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (inc) begin
            addr <= addr + 1'b1;
        end
    end

    assign last = (addr == ADDR_W'(DEPTH - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: streams bytes into instruction memory, zero-fills
// the remainder, holds the CPU in reset, then releases it. Optional running
// checksum of accepted bytes is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int DEPTH    = 16,
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int HOLD_CYC = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     s_valid,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic                     imem_we,
    output logic [$clog2(DEPTH)-1:0] imem_addr,
    output logic [DATA_W-1:0]        imem_wdata,
    output logic                     cpu_reset,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W-1:0]        checksum
);

    import cpu_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYC > 1) ? HOLD_CYC - 1 : 0);

    ld_state_t         state, state_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic              addr_clr;
    logic              addr_inc;
    logic              addr_last;
    logic              xfer;

    prog_loader_addr_ctr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (addr_clr),
        .inc   (addr_inc),
        .addr  (imem_addr),
        .last  (addr_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= LD_IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= (state == LD_HOLD) ? hold_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nx   = state;
        s_ready    = 1'b0;
        imem_we    = 1'b0;
        imem_wdata = '0;
        cpu_reset  = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        addr_clr   = 1'b0;
        addr_inc   = 1'b0;
        xfer       = 1'b0;

        case (state)
            LD_IDLE: begin
                if (start) begin
                    state_nx = LD_LOAD;
                    addr_clr = 1'b1;
                end
            end
            LD_LOAD: begin
                s_ready    = 1'b1;
                busy       = 1'b1;
                xfer       = s_valid;
                imem_we    = s_valid;
                imem_wdata = s_data;
                // The counter stops at the final word so it never wraps mid-load.
                if (s_valid) begin
                    if (addr_last) begin
                        state_nx = LD_HOLD;
                    end else begin
                        addr_inc = 1'b1;
                        if (s_last) begin
                            state_nx = LD_FILL;
                        end
                    end
                end
            end
            LD_FILL: begin
                busy    = 1'b1;
                imem_we = 1'b1;
                if (addr_last) begin
                    state_nx = LD_HOLD;
                end else begin
                    addr_inc = 1'b1;
                end
            end
            LD_HOLD: begin
                busy = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    state_nx = LD_RUN;
                end
            end
            LD_RUN: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
                if (start) begin
                    state_nx = LD_LOAD;
                    addr_clr = 1'b1;
                end
            end
            default: begin
                state_nx = LD_IDLE;
            end
        endcase

        // Reset masks the strobes in the same cycle so an aborted load writes nothing more.
        if (!reset) begin
            state_nx   = LD_IDLE;
            s_ready    = 1'b0;
            imem_we    = 1'b0;
            imem_wdata = '0;
            cpu_reset  = 1'b1;
            busy       = 1'b0;
            done       = 1'b0;
            addr_clr   = 1'b0;
            addr_inc   = 1'b0;
            xfer       = 1'b0;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sum_q <= '0;
        end else if (addr_clr) begin
            sum_q <= '0;
        end else if (xfer) begin
            sum_q <= sum_q + s_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader: expected memory images,
// hold timing and checksums come from a simple image model of the load rules.
module tb_prog_loader;

    localparam int DEPTH    = 16;
    localparam int HOLD_CYC = 2;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       start   = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       s_last  = 1'b0;
    logic       s_ready;
    logic       imem_we;
    logic [3:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic [7:0] checksum;

    int checks = 0;
    int errors = 0;

    prog_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // Write log and release timing captured away from the active edge.
    logic [3:0] wq_addr[$];
    logic [7:0] wq_data[$];
    int         wq_cyc[$];
    logic       wq_rdy[$];
    logic [7:0] stim[$];
    int         cyc = 0;
    int         done_cyc = -1;
    logic       done_prev_crst = 1'b0;
    logic       prev_crst = 1'b1;
    int         acc = 0;

    always @(negedge clk) begin
        cyc++;
        if (imem_we === 1'b1) begin
            wq_addr.push_back(imem_addr);
            wq_data.push_back(imem_wdata);
            wq_cyc.push_back(cyc);
            wq_rdy.push_back(s_ready);
        end
        if (done === 1'b1 && done_cyc < 0) begin
            done_cyc       = cyc;
            done_prev_crst = prev_crst;
        end
        prev_crst = cpu_reset;
    end

    function automatic int exp_n();
        return (stim.size() < DEPTH) ? stim.size() : DEPTH;
    endfunction

    // Memory image: accepted bytes first, zeros for the remainder.
    function automatic int bad_writes();
        int bad = 0;
        if (wq_addr.size() != DEPTH) return 1000 + wq_addr.size();
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] e;
            e = (i < exp_n()) ? stim[i] : 8'h00;
            if (wq_addr[i] !== 4'(i) || wq_data[i] !== e) bad++;
        end
        return bad;
    endfunction

    function automatic int fill_bad();
        int bad = 0;
        if (wq_addr.size() != DEPTH) return 1000 + wq_addr.size();
        for (int i = exp_n(); i < DEPTH; i++) begin
            if (wq_rdy[i] !== 1'b0) bad++;
            if (i > 0 && wq_cyc[i] != wq_cyc[i-1] + 1) bad++;
        end
        return bad;
    endfunction

    function automatic logic [7:0] exp_sum();
        logic [7:0] s = 8'h00;
`ifdef PROG_LOADER_CHECKSUM_EN
        for (int i = 0; i < exp_n(); i++) s = s + stim[i];
`endif
        return s;
    endfunction

    function automatic int hold_gap();
        if (wq_cyc.size() == 0 || done_cyc < 0) return -1;
        return done_cyc - wq_cyc[wq_cyc.size()-1];
    endfunction

    task automatic run_load(input bit do_start, input int pvalid, input bit hold_start);
        int idx;
        int budget;
        if (do_start) begin
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = hold_start;
        end
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); wq_rdy.delete();
        done_cyc = -1;
        idx = 0;
        budget = 0;
        while (idx < stim.size() && budget < 500) begin
            s_valid = ($urandom_range(0, 99) < pvalid);
            s_data  = stim[idx];
            s_last  = (idx == stim.size() - 1);
            @(negedge clk);
            if (s_ready !== 1'b1) break;
            if (s_valid) idx++;
            @(posedge clk); #1;
            budget++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
        acc     = idx;
        budget  = 0;
        while (done_cyc < 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL run_done_timeout: done never rose within 100 cycles (required done=1)");
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we: got %b want 0", imem_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (checksum !== 8'h00) begin errors++; $display("FAIL reset_checksum: got %h want 00", checksum); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || s_ready !== 1'b0 || cpu_reset !== 1'b1) begin
            errors++; $display("FAIL idle_outputs: busy=%b s_ready=%b cpu_reset=%b want 0 0 1", busy, s_ready, cpu_reset);
        end
    endtask

    task automatic test_full_load();
        stim.delete();
        for (int i = 0; i < DEPTH; i++) stim.push_back(8'(8'h10 + i));
        run_load(1'b1, 100, 1'b0);
        checks++; if (acc !== DEPTH) begin errors++; $display("FAIL full_accepted: got %0d want %0d", acc, DEPTH); end
        checks++; if (bad_writes() !== 0) begin errors++; $display("FAIL full_image: %0d bad writes want 0", bad_writes()); end
        checks++; if (hold_gap() !== HOLD_CYC + 1) begin errors++; $display("FAIL full_hold_gap: got %0d want %0d", hold_gap(), HOLD_CYC + 1); end
        checks++; if (done_prev_crst !== 1'b1) begin errors++; $display("FAIL full_hold_cpu_reset: got %b want 1", done_prev_crst); end
        checks++; if (cpu_reset !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL full_run_outputs: cpu_reset=%b done=%b busy=%b want 0 1 0", cpu_reset, done, busy);
        end
        checks++; if (checksum !== exp_sum()) begin errors++; $display("FAIL full_checksum: got %h want %h", checksum, exp_sum()); end
    endtask

    task automatic test_short_fill();
        stim = '{8'hA1, 8'hB2, 8'hC3};
        run_load(1'b1, 100, 1'b0);
        checks++; if (acc !== 3) begin errors++; $display("FAIL short_accepted: got %0d want 3", acc); end
        checks++; if (bad_writes() !== 0) begin errors++; $display("FAIL short_image: %0d bad writes want 0", bad_writes()); end
        checks++; if (fill_bad() !== 0) begin errors++; $display("FAIL short_fill_timing: %0d bad fill cycles want 0", fill_bad()); end
        checks++; if (hold_gap() !== HOLD_CYC + 1) begin errors++; $display("FAIL short_hold_gap: got %0d want %0d", hold_gap(), HOLD_CYC + 1); end
        checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL short_run: done=%b cpu_reset=%b want 1 0", done, cpu_reset); end
        checks++; if (checksum !== exp_sum()) begin errors++; $display("FAIL short_checksum: got %h want %h", checksum, exp_sum()); end
    endtask

    task automatic test_random_valid();
        stim.delete();
        for (int i = 0; i < DEPTH; i++) stim.push_back(8'($urandom));
        run_load(1'b1, 50, 1'b1);
        checks++; if (acc !== DEPTH) begin errors++; $display("FAIL rand_accepted: got %0d want %0d", acc, DEPTH); end
        checks++; if (bad_writes() !== 0) begin errors++; $display("FAIL rand_image: %0d bad writes want 0", bad_writes()); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rand_done: got %b want 1", done); end
        checks++; if (checksum !== exp_sum()) begin errors++; $display("FAIL rand_checksum: got %h want %h", checksum, exp_sum()); end
    endtask

    task automatic test_truncate();
        stim.delete();
        for (int i = 0; i < DEPTH + 4; i++) stim.push_back(8'($urandom));
        run_load(1'b1, 100, 1'b0);
        checks++; if (acc !== DEPTH) begin errors++; $display("FAIL trunc_accepted: got %0d want %0d", acc, DEPTH); end
        checks++; if (bad_writes() !== 0) begin errors++; $display("FAIL trunc_image: %0d bad writes want 0", bad_writes()); end
        checks++; if (checksum !== exp_sum()) begin errors++; $display("FAIL trunc_checksum: got %h want %h", checksum, exp_sum()); end
    endtask

    task automatic test_reset_midload();
        stim.delete();
        for (int i = 0; i < DEPTH; i++) stim.push_back(8'($urandom));
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); wq_rdy.delete();
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1;
            s_data  = stim[k];
            s_last  = 1'b0;
            @(posedge clk); #1;
        end
        reset  = 1'b0;
        s_data = stim[5];
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (imem_we !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL abort_strobes: imem_we=%b s_ready=%b want 0 0", imem_we, s_ready); end
        checks++; if (busy !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL abort_idle: busy=%b cpu_reset=%b done=%b want 0 1 0", busy, cpu_reset, done);
        end
        checks++; if (wq_addr.size() !== 5) begin errors++; $display("FAIL abort_write_count: got %0d want 5", wq_addr.size()); end
        s_valid = 1'b0;
        stim.delete();
        for (int i = 0; i < DEPTH; i++) stim.push_back(8'($urandom));
        run_load(1'b1, 100, 1'b0);
        checks++; if (bad_writes() !== 0) begin errors++; $display("FAIL abort_reload_image: %0d bad writes want 0", bad_writes()); end
        checks++; if (checksum !== exp_sum()) begin errors++; $display("FAIL abort_reload_checksum: got %h want %h", checksum, exp_sum()); end
    endtask

    task automatic test_restart_run();
        logic [7:0] want_sum;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL restart_cpu_reset: cpu_reset=%b done=%b want 1 0", cpu_reset, done); end
        checks++; if (busy !== 1'b1 || s_ready !== 1'b1) begin errors++; $display("FAIL restart_load: busy=%b s_ready=%b want 1 1", busy, s_ready); end
        @(posedge clk); #1;
        stim = '{8'hFF, 8'h02};
        run_load(1'b0, 100, 1'b0);
        checks++; if (bad_writes() !== 0) begin errors++; $display("FAIL restart_image: %0d bad writes want 0", bad_writes()); end
`ifdef PROG_LOADER_CHECKSUM_EN
        want_sum = 8'h01;
`else
        want_sum = 8'h00;
`endif
        checks++; if (checksum !== want_sum) begin errors++; $display("FAIL restart_checksum: got %h want %h", checksum, want_sum); end
        checks++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL restart_run: done=%b cpu_reset=%b want 1 0", done, cpu_reset); end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_short_fill();
        test_random_valid();
        test_truncate();
        test_reset_midload();
        test_restart_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
